// File: rtl/pcie_cfg_pkg.sv
// Shared constants and types for the PCIe DMA memory request arbiter.
// Requester IDs, FSM states and the registered memory beat layout.
package pcie_cfg_pkg;

    localparam int CFG_PCIE_DMAADDR_WIDTH = 36;

    localparam logic REQ_PIO = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        write;
        logic [9:0]  bytes;
        logic [7:0]  strob;
        logic [63:0] data;
        logic        last;
    } mem_beat_t;

endpackage

// File: rtl/pcie_id_fifo.sv
// Ordered FIFO of 1-bit requester IDs awaiting a memory response.
// Depth is a power of two; push and pop may occur in the same cycle.
module pcie_id_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_din,
    input  logic                  i_pop,
    output logic                  o_dout,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0]      mem_q, mem_d;
    logic [DEPTH_LOG2-1:0] wr_q, wr_d;
    logic [DEPTH_LOG2-1:0] rd_q, rd_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (i_push) begin
            mem_d[wr_q] = i_din;
            wr_d        = wr_q + 1'b1;
        end
        if (i_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign o_dout  = mem_q[rd_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = count_q[DEPTH_LOG2];

endmodule

// File: rtl/pcie_mem_req_arbiter.sv
// Round-robin, burst-locked arbiter sharing the memory request port
// between PIO RX (req0) and DMA (req1), with in-order response routing.
module pcie_mem_req_arbiter
    import pcie_cfg_pkg::*;
#(
    parameter int CFG_OUTSTANDING_LOG2 = 2,
    parameter int ADDR_WIDTH           = CFG_PCIE_DMAADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic                  i_req0_write,
    input  logic [9:0]            i_req0_bytes,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [7:0]            i_req0_strob,
    input  logic [63:0]           i_req0_data,
    input  logic                  i_req0_last,
    output logic                  o_resp0_valid,
    output logic [63:0]           o_resp0_data,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic                  i_req1_write,
    input  logic [9:0]            i_req1_bytes,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [7:0]            i_req1_strob,
    input  logic [63:0]           i_req1_data,
    input  logic                  i_req1_last,
    output logic                  o_resp1_valid,
    output logic [63:0]           o_resp1_data,
    input  logic                  i_req_mem_ready,
    output logic                  o_req_mem_valid,
    output logic                  o_req_mem_write,
    output logic [9:0]            o_req_mem_bytes,
    output logic [ADDR_WIDTH-1:0] o_req_mem_addr,
    output logic [7:0]            o_req_mem_strob,
    output logic [63:0]           o_req_mem_data,
    output logic                  o_req_mem_last,
    input  logic                  i_resp_mem_valid,
    input  logic [63:0]           i_resp_mem_data,
    output logic                  o_err_unexp
);

    localparam logic [CFG_OUTSTANDING_LOG2:0] DEPTH_V =
        {1'b1, {CFG_OUTSTANDING_LOG2{1'b0}}};

    arb_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  ptr_q, ptr_d;
    logic                  mem_valid_q, mem_valid_d;
    mem_beat_t             beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;

    mem_beat_t             req0_beat, req1_beat, sel_beat;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_valid;
    logic                  gnt_act, gnt_id;
    logic                  slice_free, rdy, acc, push;

    logic                  fifo_push, fifo_pop, fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CFG_OUTSTANDING_LOG2:0] fifo_count;
    logic                  resp_hit, resp_id;

    assign req0_beat = '{write: i_req0_write, bytes: i_req0_bytes,
                         strob: i_req0_strob, data: i_req0_data,
                         last: i_req0_last};
    assign req1_beat = '{write: i_req1_write, bytes: i_req1_bytes,
                         strob: i_req1_strob, data: i_req1_data,
                         last: i_req1_last};

    assign slice_free = ~mem_valid_q | i_req_mem_ready;

    // The grant is decided and used in the same cycle it is made.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gnt_act = 1'b0;
        gnt_id  = grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((i_req0_valid | i_req1_valid)
                    && (fifo_count < DEPTH_V)) begin
                    gnt_act = 1'b1;
                    gnt_id  = (i_req0_valid && i_req1_valid) ? ptr_q
                            : (i_req1_valid ? REQ_DMA : REQ_PIO);
                    grant_d = gnt_id;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: gnt_act = 1'b1;
            default:   gnt_act = 1'b0;
        endcase
        sel_beat  = (gnt_id == REQ_DMA) ? req1_beat : req0_beat;
        sel_addr  = (gnt_id == REQ_DMA) ? i_req1_addr : i_req0_addr;
        sel_valid = (gnt_id == REQ_DMA) ? i_req1_valid : i_req0_valid;
        rdy       = gnt_act & slice_free & ~i_rst;
        acc       = rdy & sel_valid;
        push      = acc & sel_beat.last;
        if (push) begin
            state_d = ST_IDLE;
            ptr_d   = ~gnt_id;
        end
    end

    always_comb begin
        mem_valid_d = mem_valid_q & ~i_req_mem_ready;
        beat_d      = beat_q;
        addr_d      = addr_q;
        if (acc) begin
            mem_valid_d = 1'b1;
            beat_d      = sel_beat;
            addr_d      = sel_addr;
        end
    end

    // An empty FIFO with a same-cycle push routes the response to that push.
    assign fifo_pop  = i_resp_mem_valid & ~fifo_empty;
    assign fifo_push = push & ~(fifo_empty & i_resp_mem_valid)
                     & (~fifo_full | fifo_pop);
    assign resp_hit  = i_resp_mem_valid & (~fifo_empty | push);
    assign resp_id   = fifo_empty ? gnt_id : fifo_head;
    assign err_d     = err_q | (i_resp_mem_valid & fifo_empty & ~push);

    pcie_id_fifo #(
        .DEPTH_LOG2 (CFG_OUTSTANDING_LOG2)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_din   (gnt_id),
        .i_pop   (fifo_pop),
        .o_dout  (fifo_head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= REQ_PIO;
            ptr_q       <= REQ_PIO;
            mem_valid_q <= 1'b0;
            beat_q      <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            mem_valid_q <= mem_valid_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
        end
    end

    assign o_req0_ready    = rdy & (gnt_id == REQ_PIO);
    assign o_req1_ready    = rdy & (gnt_id == REQ_DMA);
    assign o_resp0_valid   = resp_hit & (resp_id == REQ_PIO);
    assign o_resp1_valid   = resp_hit & (resp_id == REQ_DMA);
    assign o_resp0_data    = o_resp0_valid ? i_resp_mem_data : '0;
    assign o_resp1_data    = o_resp1_valid ? i_resp_mem_data : '0;
    assign o_req_mem_valid = mem_valid_q;
    assign o_req_mem_write = beat_q.write;
    assign o_req_mem_bytes = beat_q.bytes;
    assign o_req_mem_addr  = addr_q;
    assign o_req_mem_strob = beat_q.strob;
    assign o_req_mem_data  = beat_q.data;
    assign o_req_mem_last  = beat_q.last;
    assign o_err_unexp     = err_q;

endmodule

// File: tb/tb_pcie_mem_req_arbiter.sv
// Directed testbench for pcie_mem_req_arbiter.
// Inputs driven 1ns after the rising edge; outputs sampled 1ns later.
module tb_pcie_mem_req_arbiter;
    import pcie_cfg_pkg::*;

    localparam int AW = CFG_PCIE_DMAADDR_WIDTH;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req0_valid, o_req0_ready, i_req0_write, i_req0_last;
    logic [9:0]    i_req0_bytes;
    logic [AW-1:0] i_req0_addr;
    logic [7:0]    i_req0_strob;
    logic [63:0]   i_req0_data;
    logic          o_resp0_valid;
    logic [63:0]   o_resp0_data;
    logic          i_req1_valid, o_req1_ready, i_req1_write, i_req1_last;
    logic [9:0]    i_req1_bytes;
    logic [AW-1:0] i_req1_addr;
    logic [7:0]    i_req1_strob;
    logic [63:0]   i_req1_data;
    logic          o_resp1_valid;
    logic [63:0]   o_resp1_data;
    logic          i_req_mem_ready, o_req_mem_valid, o_req_mem_write;
    logic [9:0]    o_req_mem_bytes;
    logic [AW-1:0] o_req_mem_addr;
    logic [7:0]    o_req_mem_strob;
    logic [63:0]   o_req_mem_data;
    logic          o_req_mem_last;
    logic          i_resp_mem_valid;
    logic [63:0]   i_resp_mem_data;
    logic          o_err_unexp;

    int n_tests = 0;
    int n_fail  = 0;

    pcie_mem_req_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_write(i_req0_write), .i_req0_bytes(i_req0_bytes),
        .i_req0_addr(i_req0_addr), .i_req0_strob(i_req0_strob),
        .i_req0_data(i_req0_data), .i_req0_last(i_req0_last),
        .o_resp0_valid(o_resp0_valid), .o_resp0_data(o_resp0_data),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_write(i_req1_write), .i_req1_bytes(i_req1_bytes),
        .i_req1_addr(i_req1_addr), .i_req1_strob(i_req1_strob),
        .i_req1_data(i_req1_data), .i_req1_last(i_req1_last),
        .o_resp1_valid(o_resp1_valid), .o_resp1_data(o_resp1_data),
        .i_req_mem_ready(i_req_mem_ready),
        .o_req_mem_valid(o_req_mem_valid), .o_req_mem_write(o_req_mem_write),
        .o_req_mem_bytes(o_req_mem_bytes), .o_req_mem_addr(o_req_mem_addr),
        .o_req_mem_strob(o_req_mem_strob), .o_req_mem_data(o_req_mem_data),
        .o_req_mem_last(o_req_mem_last),
        .i_resp_mem_valid(i_resp_mem_valid), .i_resp_mem_data(i_resp_mem_data),
        .o_err_unexp(o_err_unexp)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req0_valid = 0; i_req0_write = 0; i_req0_bytes = '0; i_req0_addr = '0;
        i_req0_strob = '0; i_req0_data = '0; i_req0_last = 0;
        i_req1_valid = 0; i_req1_write = 0; i_req1_bytes = '0; i_req1_addr = '0;
        i_req1_strob = '0; i_req1_data = '0; i_req1_last = 0;
        i_req_mem_ready = 1; i_resp_mem_valid = 0; i_resp_mem_data = '0;
    endtask

    task automatic do_reset();
        i_rst = 1;
        idle_inputs();
        cyc();
        cyc();
        i_rst = 0;
    endtask

    task automatic rd0(input logic [AW-1:0] a);
        i_req0_valid = 1; i_req0_write = 0; i_req0_bytes = 10'd4;
        i_req0_addr = a; i_req0_strob = 8'h00; i_req0_last = 1;
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        i_req1_valid = 1; i_req1_write = 0; i_req1_bytes = 10'd8;
        i_req1_addr = a; i_req1_strob = 8'h00; i_req1_last = 1;
    endtask

    task automatic test_reset();
        i_rst = 1;
        idle_inputs();
        i_req0_valid = 1;
        i_req0_last = 1;
        #1;
        n_tests++;
        if ({o_req_mem_valid, o_req_mem_write, o_req_mem_last, o_req0_ready,
             o_req1_ready, o_resp0_valid, o_resp1_valid, o_err_unexp} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b%b%b%b%b%b%b%b exp 00000000",
                     o_req_mem_valid, o_req_mem_write, o_req_mem_last, o_req0_ready,
                     o_req1_ready, o_resp0_valid, o_resp1_valid, o_err_unexp);
        end
        n_tests++;
        if ({o_req_mem_addr, o_req_mem_data, o_req_mem_bytes, o_req_mem_strob} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h data=%h exp 0", o_req_mem_addr, o_req_mem_data);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        rd0(36'h008000010);
        #1;
        n_tests++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0 || o_req_mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ready got r0=%b r1=%b mv=%b exp 1 0 0",
                     o_req0_ready, o_req1_ready, o_req_mem_valid);
        end
        cyc();
        i_req0_valid = 0;
        n_tests++;
        if (o_req_mem_valid !== 1'b1 || o_req_mem_addr !== 36'h008000010 ||
            o_req_mem_bytes !== 10'd4 || o_req_mem_write !== 1'b0 || o_req_mem_last !== 1'b1) begin
            n_fail++;
            $display("FAIL read_slice got v=%b a=%h b=%0d w=%b l=%b exp 1 008000010 4 0 1",
                     o_req_mem_valid, o_req_mem_addr, o_req_mem_bytes,
                     o_req_mem_write, o_req_mem_last);
        end
        cyc();
        n_tests++;
        if (o_req_mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_slice_clear got %b exp 0", o_req_mem_valid);
        end
        i_resp_mem_valid = 1;
        i_resp_mem_data = 64'hDEADBEEF_01234567;
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b1 || o_resp1_valid !== 1'b0 ||
            o_resp0_data !== 64'hDEADBEEF_01234567) begin
            n_fail++;
            $display("FAIL read_resp got v0=%b v1=%b d=%h exp 1 0 deadbeef01234567",
                     o_resp0_valid, o_resp1_valid, o_resp0_data);
        end
        cyc();
        i_resp_mem_valid = 0;
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b0 || o_err_unexp !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp_pulse got v0=%b err=%b exp 0 0", o_resp0_valid, o_err_unexp);
        end
    endtask

    task automatic test_contention();
        do_reset();
        rd0(36'h000000100);
        rd1(36'h000000200);
        #1;
        n_tests++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_first got r0=%b r1=%b exp 1 0", o_req0_ready, o_req1_ready);
        end
        cyc();
        n_tests++;
        if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b1 || o_req_mem_addr !== 36'h000000100) begin
            n_fail++;
            $display("FAIL contend_second got r0=%b r1=%b a=%h exp 0 1 000000100",
                     o_req0_ready, o_req1_ready, o_req_mem_addr);
        end
        cyc();
        i_req0_valid = 0;
        i_req1_valid = 0;
        n_tests++;
        if (o_req_mem_addr !== 36'h000000200 || o_req_mem_bytes !== 10'd8) begin
            n_fail++;
            $display("FAIL contend_slice got a=%h b=%0d exp 000000200 8", o_req_mem_addr, o_req_mem_bytes);
        end
        i_resp_mem_valid = 1;
        i_resp_mem_data = 64'h1111;
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b1 || o_resp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_resp0 got v0=%b v1=%b exp 1 0", o_resp0_valid, o_resp1_valid);
        end
        cyc();
        i_resp_mem_data = 64'h2222;
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b0 || o_resp1_valid !== 1'b1 || o_resp1_data !== 64'h2222) begin
            n_fail++;
            $display("FAIL contend_resp1 got v0=%b v1=%b d=%h exp 0 1 2222",
                     o_resp0_valid, o_resp1_valid, o_resp1_data);
        end
        cyc();
        i_resp_mem_valid = 0;
    endtask

    task automatic test_dma_burst();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_req1_valid = 1; i_req1_write = 1; i_req1_bytes = 10'd32;
            i_req1_addr = 36'h0000A0000; i_req1_strob = 8'hFF;
            i_req1_data = 64'hA000_0000_0000_0000 + 64'(i);
            i_req1_last = (i == 3);
            if (i > 0) rd0(36'h000000300);
            #1;
            n_tests++;
            if (o_req1_ready !== 1'b1 || o_req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL burst_ready beat %0d got r1=%b r0=%b exp 1 0",
                         i, o_req1_ready, o_req0_ready);
            end
            cyc();
            n_tests++;
            if (o_req_mem_valid !== 1'b1 || o_req_mem_write !== 1'b1 ||
                o_req_mem_strob !== 8'hFF ||
                o_req_mem_data !== 64'hA000_0000_0000_0000 + 64'(i) ||
                o_req_mem_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL burst_beat %0d got v=%b w=%b s=%h d=%h l=%b",
                         i, o_req_mem_valid, o_req_mem_write, o_req_mem_strob,
                         o_req_mem_data, o_req_mem_last);
            end
        end
        i_req1_valid = 0;
        #1;
        n_tests++;
        if (o_req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_pio_after got r0=%b exp 1", o_req0_ready);
        end
        cyc();
        i_req0_valid = 0;
        n_tests++;
        if (o_req_mem_addr !== 36'h000000300 || o_req_mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_pio_slice got a=%h w=%b exp 000000300 0",
                     o_req_mem_addr, o_req_mem_write);
        end
        i_resp_mem_valid = 1;
        #1;
        n_tests++;
        if (o_resp1_valid !== 1'b1 || o_resp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_resp_dma got v1=%b v0=%b exp 1 0", o_resp1_valid, o_resp0_valid);
        end
        cyc();
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b1 || o_resp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_resp_pio got v0=%b v1=%b exp 1 0", o_resp0_valid, o_resp1_valid);
        end
        cyc();
        i_resp_mem_valid = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            i_req1_valid = 1; i_req1_write = 1; i_req1_bytes = 10'd24;
            i_req1_addr = 36'h0000B0000 + 36'(i * 8); i_req1_strob = 8'hFF;
            i_req1_data = 64'hB0 + 64'(i); i_req1_last = 0;
            cyc();
        end
        i_req_mem_ready = 0;
        i_req1_addr = 36'h0000B0010; i_req1_data = 64'hB2; i_req1_last = 1;
        #1;
        n_tests++;
        if (o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low got %b exp 0", o_req1_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++;
            if (o_req_mem_valid !== 1'b1 || o_req_mem_data !== 64'hB1 ||
                o_req_mem_addr !== 36'h0000B0008 || o_req_mem_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h a=%h l=%b exp 1 b1 0000b0008 0",
                         k, o_req_mem_valid, o_req_mem_data, o_req_mem_addr, o_req_mem_last);
            end
        end
        i_req_mem_ready = 1;
        #1;
        n_tests++;
        if (o_req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_resume got %b exp 1", o_req1_ready);
        end
        cyc();
        i_req1_valid = 0;
        n_tests++;
        if (o_req_mem_valid !== 1'b1 || o_req_mem_data !== 64'hB2 ||
            o_req_mem_addr !== 36'h0000B0010 || o_req_mem_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_last got v=%b d=%h a=%h l=%b exp 1 b2 0000b0010 1",
                     o_req_mem_valid, o_req_mem_data, o_req_mem_addr, o_req_mem_last);
        end
        cyc();
        n_tests++;
        if (o_req_mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup got v=%b exp 0", o_req_mem_valid);
        end
        i_resp_mem_valid = 1;
        #1;
        n_tests++;
        if (o_resp1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resp got v1=%b exp 1", o_resp1_valid);
        end
        cyc();
        i_resp_mem_valid = 0;
    endtask

    task automatic test_outstanding();
        logic exp_id [5];
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0; exp_id[3] = 1; exp_id[4] = 0;
        do_reset();
        rd0(36'h000000400);
        rd1(36'h000000500);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (o_req0_ready !== (k % 2 == 0) || o_req1_ready !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL out_grant %0d got r0=%b r1=%b", k, o_req0_ready, o_req1_ready);
            end
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL out_full %0d got r0=%b r1=%b exp 0 0", k, o_req0_ready, o_req1_ready);
            end
            cyc();
        end
        i_resp_mem_valid = 1;
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b1 || o_resp1_valid !== 1'b0 || o_req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL out_pop0 got v0=%b v1=%b r0=%b exp 1 0 0",
                     o_resp0_valid, o_resp1_valid, o_req0_ready);
        end
        cyc();
        i_resp_mem_valid = 0;
        #1;
        n_tests++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL out_fifth got r0=%b r1=%b exp 1 0", o_req0_ready, o_req1_ready);
        end
        cyc();
        i_req0_valid = 0;
        i_req1_valid = 0;
        i_resp_mem_valid = 1;
        for (int k = 1; k < 5; k++) begin
            #1;
            n_tests++;
            if (o_resp0_valid !== ~exp_id[k] || o_resp1_valid !== exp_id[k]) begin
                n_fail++;
                $display("FAIL out_route %0d got v0=%b v1=%b exp id %0d",
                         k, o_resp0_valid, o_resp1_valid, exp_id[k]);
            end
            cyc();
        end
        i_resp_mem_valid = 0;
        #1;
        n_tests++;
        if (o_err_unexp !== 1'b0) begin
            n_fail++;
            $display("FAIL out_no_err got %b exp 0", o_err_unexp);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        i_resp_mem_valid = 1;
        i_resp_mem_data = 64'h5555;
        #1;
        n_tests++;
        if (o_resp0_valid !== 1'b0 || o_resp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_drop got v0=%b v1=%b exp 0 0", o_resp0_valid, o_resp1_valid);
        end
        cyc();
        i_resp_mem_valid = 0;
        cyc();
        cyc();
        n_tests++;
        if (o_err_unexp !== 1'b1) begin
            n_fail++;
            $display("FAIL unexp_sticky got %b exp 1", o_err_unexp);
        end
        i_rst = 1;
        #1;
        n_tests++;
        if (o_err_unexp !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_reset got %b exp 0", o_err_unexp);
        end
        cyc();
        i_rst = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_dma_burst();
        test_backpressure();
        test_outstanding();
        test_unexpected();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_mem_req_arbiter.md
Name: pcie_mem_req_arbiter

Overview:
Two-requester arbiter for the PCIe DMA memory request channel. It shares one memory request/response port between the PIO RX engine (requester 0) and the DMA engine (requester 1). Grants are round-robin and locked for the whole burst, from grant until the beat with last=1. The block keeps an ordered FIFO of requester IDs so each memory response is returned to the requester that issued the transaction.

Parameters:
- CFG_OUTSTANDING_LOG2, 2, log2 of the maximum number of transactions awaiting response (FIFO depth 4).
- ADDR_WIDTH, pcie_cfg_pkg::CFG_PCIE_DMAADDR_WIDTH, memory address width.

Ports:
- i_clk  in  1  single system bus clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req0_valid / i_req1_valid  in  1  request beat valid (PIO / DMA).
- o_req0_ready / o_req1_ready  out  1  beat accepted this cycle.
- i_reqN_write  in  1  0=read, 1=write.
- i_reqN_bytes  in  10  byte count; 0=1024.
- i_reqN_addr  in  ADDR_WIDTH  address.
- i_reqN_strob  in  8  byte write strobe.
- i_reqN_data  in  64  write data.
- i_reqN_last  in  1  last beat of transaction; reads are always single beat with last=1.
- o_respN_valid  out  1  response for requester N.
- o_respN_data  out  64  read data (copy of i_resp_mem_data).
- i_req_mem_ready  in  1  memory accepts the registered beat.
- o_req_mem_valid, o_req_mem_write, o_req_mem_bytes[9:0], o_req_mem_addr[ADDR_WIDTH], o_req_mem_strob[7:0], o_req_mem_data[63:0], o_req_mem_last  out  registered request slice.
- i_resp_mem_valid  in  1  one response per transaction (per last beat).
- i_resp_mem_data  in  64  response data.
- o_err_unexp  out  1  sticky flag: response received with no outstanding transaction.

Behaviour:
- Reset: every output is 0. State IDLE, grant=0, priority pointer=0, FIFO empty, count=0.
- FSM, IDLE:
  - A new grant is allowed only when FIFO count < 2^CFG_OUTSTANDING_LOG2.
  - If both requesters are valid, grant the one named by the priority pointer; otherwise grant the single valid one.
  - Move to LOCKED in the same cycle the grant is made (the first beat may be accepted that cycle).
- FSM, LOCKED: stay until the granted requester's beat with last=1 is accepted. Then return to IDLE and set the pointer to the other requester.
- Beat acceptance:
  - o_reqG_ready = granted & (~o_req_mem_valid | i_req_mem_ready), combinational.
  - The non-granted requester's ready is 0.
  - An accepted beat loads the output slice next cycle, giving 1-cycle latency.
  - The slice holds its value while valid & ~i_req_mem_ready.
  - It clears valid on i_req_mem_ready when no new beat is loaded.
- Back-to-back: a last beat and the next grant's first beat may issue on consecutive cycles. No bubble is required, but one IDLE cycle is permitted.
- ID FIFO:
  - Push the granted ID when a beat with last=1 is accepted.
  - Pop on i_resp_mem_valid. The head ID steers o_respN_valid (1-cycle pulse, same cycle, combinational from FIFO head) and the data.
- Simultaneous push and pop: count is unchanged, and the pop uses the old head.
- Response while FIFO is empty (and no push the same cycle): drop it, set o_err_unexp=1 and keep it set until reset.
- FIFO full: no new grant. A burst in progress cannot overflow, because its push was reserved when the grant was made (count < depth check).
- Requester drops valid mid-burst: the lock is held and no beats are issued until it resumes.
- Reset asserted mid-burst: everything clears immediately and outstanding responses are forgotten.

Decomposition:
- pcie_cfg_pkg holds the requester ID constants (REQ_PIO=0, REQ_DMA=1), the FSM state localparams and a memory request beat struct typedef.
- Sub-module pcie_id_fifo: synchronous FIFO, width 1, parameterised depth, exposing count/full/empty and allowing simultaneous push/pop.

Test Plan:
- Single PIO read (addr=0x008000010, bytes=4, last=1) → mem_valid one cycle later, then resp0_valid with data 0xDEADBEEF_01234567. resp1_valid stays 0.
- Both requesters valid in the same cycle after reset → req0 is granted first. The next contention grants req1, confirming pointer alternation.
- DMA write burst of 4 beats (last on beat 4) with PIO valid throughout → PIO ready stays 0 until DMA beat 4 is accepted. mem beats are in order with strob 0xFF.
- i_req_mem_ready low for 3 cycles mid-burst → the output slice holds data and addr unchanged, and no beat is lost or duplicated.
- Issue 4 reads with responses withheld → a 5th request is not granted until one response arrives. Responses are routed 0,1,0,1 matching issue order.
- i_resp_mem_valid with FIFO empty → no resp pulses, and o_err_unexp=1 until i_rst.
